// File: rtl/sync_down_counter_if.sv
// Bundle of the counter's control inputs and status outputs.
// master drives controls and observes status; slave is the counter itself.
interface sync_down_counter_if #(
    parameter int unsigned W = 4
);
    logic         c_enable;
    logic         load;
    logic [W-1:0] D;
    logic         auto_reload;
    logic [W-1:0] Q;
    logic         borrow;
    logic         done;
    logic         wrap;

    modport master (
        output c_enable, load, D, auto_reload,
        input  Q, borrow, done, wrap
    );

    modport slave (
        input  c_enable, load, D, auto_reload,
        output Q, borrow, done, wrap
    );
endinterface

// File: rtl/sync_down_counter.sv
// Programmable synchronous down counter/timer with reload register.
// At zero it either reloads from R (pulsing wrap) or stops and sets a sticky done.
// borrow is combinational so stages can be cascaded into wider counters.
module sync_down_counter #(
    parameter int unsigned W = 4
) (
    input  logic               clock,
    input  logic               clear,
    sync_down_counter_if.slave bus
);
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] r_q, r_d;
    logic         done_q, done_d;
    logic         wrap_q, wrap_d;
    logic         q_zero;

    assign q_zero = (q_q == '0);

    // Next-state: load beats everything; then enable gating; then count/reload/stop.
    always_comb begin
        q_d    = q_q;
        r_d    = r_q;
        done_d = done_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            q_d    = bus.D;
            r_d    = bus.D;
            done_d = 1'b0;
        end else if (bus.c_enable) begin
            if (!q_zero) begin
                q_d = q_q - W'(1);
            end else if (bus.auto_reload) begin
                // Reload also applies with R=0, so wrap pulses every enabled cycle.
                q_d    = r_q;
                wrap_d = 1'b1;
            end else begin
                done_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q_q    <= '0;
            r_q    <= '0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            r_q    <= r_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.Q      = q_q;
    assign bus.done   = done_q;
    assign bus.wrap   = wrap_q;
    // Feeds c_enable of the next-higher stage; zero latency from Q and c_enable.
    assign bus.borrow = bus.c_enable & q_zero;

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter: directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_sync_down_counter;
    localparam int unsigned W = 4;

    logic clock;
    logic clear;
    int   n_checks;
    int   n_errors;
    bit   run_model;

    // Reference model state for the low stage
    logic [W-1:0] m_q, m_r;
    logic         m_done, m_wrap;

    sync_down_counter_if #(.W(W)) bus_lo ();
    sync_down_counter_if #(.W(W)) bus_hi ();

    sync_down_counter #(.W(W)) u_lo (
        .clock (clock),
        .clear (clear),
        .bus   (bus_lo)
    );

    sync_down_counter #(.W(W)) u_hi (
        .clock (clock),
        .clear (clear),
        .bus   (bus_hi)
    );

    // High stage is permanently cascaded off the low stage's borrow.
    assign bus_hi.c_enable = bus_lo.borrow;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Applies the specification's edge rules to the model using current inputs.
    task automatic model_edge();
        if (bus_lo.load) begin
            m_q    = bus_lo.D;
            m_r    = bus_lo.D;
            m_done = 1'b0;
            m_wrap = 1'b0;
        end else if (!bus_lo.c_enable) begin
            m_wrap = 1'b0;
        end else if (m_q != 0) begin
            m_q    = m_q - 4'd1;
            m_wrap = 1'b0;
        end else if (bus_lo.auto_reload) begin
            m_q    = m_r;
            m_wrap = 1'b1;
        end else begin
            m_done = 1'b1;
            m_wrap = 1'b0;
        end
    endtask

    // One rising edge; returns on the following falling edge where outputs are sampled.
    task automatic tick();
        @(posedge clock);
        if (run_model && clear) model_edge();
        @(negedge clock);
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({bus_lo.Q, bus_lo.done, bus_lo.wrap, bus_lo.borrow} !== 7'b0000_000) begin
            n_errors++;
            $display("FAIL reset_state: got Q=%0d done=%b wrap=%b borrow=%b, expected all 0",
                     bus_lo.Q, bus_lo.done, bus_lo.wrap, bus_lo.borrow);
        end
        bus_lo.c_enable = 1'b1;
        #1;
        n_checks++;
        if (bus_lo.borrow !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_borrow: got %b, expected 1", bus_lo.borrow);
        end
        bus_lo.load = 1'b1;
        bus_lo.D    = 4'd5;
        @(posedge clock);
        #1;
        n_checks++;
        if (bus_lo.Q !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_holds_q: got %0d, expected 0", bus_lo.Q);
        end
        @(negedge clock);
        bus_lo.load     = 1'b0;
        bus_lo.c_enable = 1'b0;
        clear           = 1'b1;
    endtask

    task automatic test_one_shot();
        logic [W-1:0] exp_q [5] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
        bus_lo.load = 1'b1; bus_lo.D = 4'd3; bus_lo.auto_reload = 1'b0; bus_lo.c_enable = 1'b1;
        tick();
        bus_lo.load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({bus_lo.Q, bus_lo.done, bus_lo.wrap} !== {exp_q[i], (i >= 4), 1'b0}) begin
                n_errors++;
                $display("FAIL one_shot[%0d]: got Q=%0d done=%b wrap=%b, expected Q=%0d done=%b wrap=0",
                         i, bus_lo.Q, bus_lo.done, bus_lo.wrap, exp_q[i], (i >= 4));
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_auto_reload();
        logic [W-1:0] exp_q [9] = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0};
        bus_lo.load = 1'b1; bus_lo.D = 4'd2; bus_lo.auto_reload = 1'b1; bus_lo.c_enable = 1'b1;
        tick();
        bus_lo.load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if ({bus_lo.Q, bus_lo.wrap, bus_lo.borrow, bus_lo.done} !==
                {exp_q[i], (i > 0 && i % 3 == 0), (i % 3 == 2), 1'b0}) begin
                n_errors++;
                $display("FAIL auto_reload[%0d]: got Q=%0d wrap=%b borrow=%b done=%b, expected Q=%0d wrap=%b borrow=%b done=0",
                         i, bus_lo.Q, bus_lo.wrap, bus_lo.borrow, bus_lo.done,
                         exp_q[i], (i > 0 && i % 3 == 0), (i % 3 == 2));
            end
            tick();
        end
    endtask

    task automatic test_enable_load();
        // Reach Q=5 by counting down from 7
        bus_lo.load = 1'b1; bus_lo.D = 4'd7; bus_lo.auto_reload = 1'b0; bus_lo.c_enable = 1'b1;
        tick();
        bus_lo.load = 1'b0;
        tick();
        tick();
        bus_lo.c_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({bus_lo.Q, bus_lo.wrap} !== {4'd5, 1'b0}) begin
                n_errors++;
                $display("FAIL enable_hold[%0d]: got Q=%0d wrap=%b, expected Q=5 wrap=0",
                         i, bus_lo.Q, bus_lo.wrap);
            end
        end
        bus_lo.load = 1'b1; bus_lo.D = 4'd9; bus_lo.c_enable = 1'b1;
        tick();
        bus_lo.load = 1'b0;
        n_checks++;
        if ({bus_lo.Q, bus_lo.done, bus_lo.wrap} !== {4'd9, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL load_priority: got Q=%0d done=%b wrap=%b, expected Q=9 done=0 wrap=0",
                     bus_lo.Q, bus_lo.done, bus_lo.wrap);
        end
    endtask

    task automatic test_edge_values();
        bus_lo.load = 1'b1; bus_lo.D = 4'd0; bus_lo.auto_reload = 1'b1; bus_lo.c_enable = 1'b1;
        tick();
        bus_lo.load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({bus_lo.Q, bus_lo.wrap, bus_lo.borrow, bus_lo.done} !== {4'd0, 3'b110}) begin
                n_errors++;
                $display("FAIL zero_reload[%0d]: got Q=%0d wrap=%b borrow=%b done=%b, expected Q=0 wrap=1 borrow=1 done=0",
                         i, bus_lo.Q, bus_lo.wrap, bus_lo.borrow, bus_lo.done);
            end
        end
        bus_lo.load = 1'b1; bus_lo.auto_reload = 1'b0;
        tick();
        bus_lo.load = 1'b0;
        n_checks++;
        if ({bus_lo.Q, bus_lo.done, bus_lo.wrap} !== {4'd0, 2'b00}) begin
            n_errors++;
            $display("FAIL zero_load_not_done: got Q=%0d done=%b wrap=%b, expected Q=0 done=0 wrap=0",
                     bus_lo.Q, bus_lo.done, bus_lo.wrap);
        end
        tick();
        n_checks++;
        if ({bus_lo.Q, bus_lo.done, bus_lo.wrap} !== {4'd0, 2'b10}) begin
            n_errors++;
            $display("FAIL zero_done: got Q=%0d done=%b wrap=%b, expected Q=0 done=1 wrap=0",
                     bus_lo.Q, bus_lo.done, bus_lo.wrap);
        end
        // DONE survives a disabled cycle and an auto-reload cycle
        bus_lo.c_enable = 1'b0;
        tick();
        n_checks++;
        if ({bus_lo.done, bus_lo.wrap, bus_lo.borrow} !== 3'b100) begin
            n_errors++;
            $display("FAIL done_sticky_idle: got done=%b wrap=%b borrow=%b, expected 1 0 0",
                     bus_lo.done, bus_lo.wrap, bus_lo.borrow);
        end
        bus_lo.c_enable = 1'b1; bus_lo.auto_reload = 1'b1;
        tick();
        n_checks++;
        if ({bus_lo.Q, bus_lo.done, bus_lo.wrap} !== {4'd0, 2'b11}) begin
            n_errors++;
            $display("FAIL done_sticky_reload: got Q=%0d done=%b wrap=%b, expected Q=0 done=1 wrap=1",
                     bus_lo.Q, bus_lo.done, bus_lo.wrap);
        end
    endtask

    task automatic test_async_clear();
        bus_lo.load = 1'b1; bus_lo.D = 4'd9; bus_lo.auto_reload = 1'b0; bus_lo.c_enable = 1'b1;
        tick();
        bus_lo.load = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus_lo.Q, bus_lo.done} !== {4'd7, 1'b0}) begin
            n_errors++;
            $display("FAIL pre_clear: got Q=%0d done=%b, expected Q=7 done=0", bus_lo.Q, bus_lo.done);
        end
        #2;
        clear = 1'b0;
        #1;
        n_checks++;
        if ({bus_lo.Q, bus_lo.done, bus_lo.wrap} !== {4'd0, 2'b00}) begin
            n_errors++;
            $display("FAIL async_clear: got Q=%0d done=%b wrap=%b, expected all 0",
                     bus_lo.Q, bus_lo.done, bus_lo.wrap);
        end
        @(negedge clock);
        clear = 1'b1;
        bus_lo.auto_reload = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({bus_lo.Q, bus_lo.wrap} !== {4'd0, 1'b1}) begin
                n_errors++;
                $display("FAIL clear_loses_r[%0d]: got Q=%0d wrap=%b, expected Q=0 wrap=1",
                         i, bus_lo.Q, bus_lo.wrap);
            end
        end
    endtask

    task automatic test_cascade();
        bus_lo.load = 1'b1; bus_lo.D = 4'd15; bus_lo.auto_reload = 1'b1; bus_lo.c_enable = 1'b1;
        bus_hi.load = 1'b1; bus_hi.D = 4'd1;  bus_hi.auto_reload = 1'b1;
        tick();
        bus_lo.load = 1'b0;
        bus_hi.load = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        n_checks++;
        if ({bus_lo.Q, bus_lo.borrow, bus_hi.Q} !== {4'd0, 1'b1, 4'd1}) begin
            n_errors++;
            $display("FAIL cascade_before: got lo=%0d borrow=%b hi=%0d, expected lo=0 borrow=1 hi=1",
                     bus_lo.Q, bus_lo.borrow, bus_hi.Q);
        end
        tick();
        n_checks++;
        if ({bus_lo.Q, bus_lo.wrap, bus_hi.Q} !== {4'd15, 1'b1, 4'd0}) begin
            n_errors++;
            $display("FAIL cascade_after: got lo=%0d wrap=%b hi=%0d, expected lo=15 wrap=1 hi=0",
                     bus_lo.Q, bus_lo.wrap, bus_hi.Q);
        end
    endtask

    task automatic test_random();
        // Resynchronise model and DUT through a clear pulse
        #2;
        clear = 1'b0;
        m_q = '0; m_r = '0; m_done = 1'b0; m_wrap = 1'b0;
        bus_lo.load = 1'b0;
        @(negedge clock);
        clear     = 1'b1;
        run_model = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus_lo.load        = ($urandom_range(0, 7) == 0);
            bus_lo.D           = 4'($urandom_range(0, 15));
            bus_lo.c_enable    = ($urandom_range(0, 3) != 0);
            bus_lo.auto_reload = ($urandom_range(0, 2) != 0);
            tick();
            n_checks++;
            if ({bus_lo.Q, bus_lo.done, bus_lo.wrap, bus_lo.borrow} !==
                {m_q, m_done, m_wrap, bus_lo.c_enable & (m_q == 0)}) begin
                n_errors++;
                $display("FAIL random[%0d]: got Q=%0d done=%b wrap=%b borrow=%b, expected Q=%0d done=%b wrap=%b borrow=%b",
                         i, bus_lo.Q, bus_lo.done, bus_lo.wrap, bus_lo.borrow,
                         m_q, m_done, m_wrap, bus_lo.c_enable & (m_q == 0));
            end
        end
        run_model = 1'b0;
    endtask

    initial begin
        n_checks           = 0;
        n_errors           = 0;
        run_model          = 1'b0;
        clear              = 1'b0;
        bus_lo.c_enable    = 1'b0;
        bus_lo.load        = 1'b0;
        bus_lo.D           = '0;
        bus_lo.auto_reload = 1'b0;
        bus_hi.load        = 1'b0;
        bus_hi.D           = '0;
        bus_hi.auto_reload = 1'b0;
        m_q = '0; m_r = '0; m_done = 1'b0; m_wrap = 1'b0;

        test_reset();
        test_one_shot();
        test_auto_reload();
        test_enable_load();
        test_edge_values();
        test_async_clear();
        test_cascade();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
